fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage, for the pipelined core.
- Generates sequential PCs, issues requests to instruction memory through a valid/ready handshake, and buffers in-order responses with their PCs in a DEPTH-entry queue.
- Delivers the buffered instructions to decode through a valid/ready handshake.
- Supports a branch redirect that flushes the queue and discards stale in-flight responses.

Parameters:
- N, 64, address/PC width.
- INSN_W, 32, instruction width; PC step = INSN_W/8; must be a multiple of 8.
- DEPTH, 4, queue entries; power of 2, at least 2.
- RESET_PC, 0, PC loaded at reset (N bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- redirect_F  in  1  branch taken or redirect request.
- PCBranch_F  in  N  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr_F  out  N  request address (current fetch PC).
- imem_rsp_valid  in  1  response valid; in request order, at least 1 cycle after acceptance, never back-pressured.
- imem_rsp_data  in  INSN_W  response instruction.
- instr_valid_D  out  1  instruction available to decode.
- instr_ready_D  in  1  decode accepts.
- instr_D  out  INSN_W  instruction at queue head.
- pc_D  out  N  PC of instr_D.

Behaviour:
- Reset (reset==0 at an edge):
  - pc=RESET_PC.
  - Queue empty: alloc, fill and head pointers = 0; count = 0.
  - inflight = 0, stale = 0.
  - imem_req_valid = 0, instr_valid_D = 0.
  - instr_D and pc_D = 0 (zero while the queue is empty).
  - Reset mid-operation discards everything; responses arriving after reset for pre-reset requests are undefined, and the bench must not produce them.
- Counters: count (allocated entries) and inflight (accepted, unanswered requests), each clog2(DEPTH)+1 bits.
- Request side:
  - imem_req_valid = reset && !redirect_F && count<DEPTH && inflight<DEPTH.
  - imem_addr_F = pc.
  - On accept (valid && ready): allocate entry[alloc_ptr] with its pc and filled=0; alloc_ptr++ (mod DEPTH); pc += INSN_W/8, wrapping mod 2^N; inflight++.
- Response side, on imem_rsp_valid:
  - inflight-- in every case.
  - If stale>0: stale-- and the data is discarded.
  - Otherwise: entry[fill_ptr] gets data and filled=1; fill_ptr++.
- Decode side:
  - instr_valid_D = !redirect_F && count>0 && entry[head].filled.
  - instr_D and pc_D come from entry[head].
  - On valid && ready: head++, count--.
  - Latency: a response is visible on instr_valid_D the cycle after imem_rsp_valid; no bypass.
- Redirect (redirect_F==1), with priority over all other actions that cycle:
  - pc <- PCBranch_F.
  - Queue flushed: count = 0, all pointers = 0, filled bits cleared.
  - stale <- inflight - imem_rsp_valid. That is every request still outstanding after this cycle, old or already stale; the response this cycle is processed first.
  - No request is issued and no decode handshake occurs that cycle.
  - The first request to the target goes out the next cycle.
- Simultaneous events in one cycle: accept, response and decode pop all take effect; count and inflight net correctly (e.g. +1 and -1 leaves the value unchanged).
- Full queue: count==DEPTH blocks requests. Empty queue, or head not yet filled: instr_valid_D = 0.
- Back-to-back redirects: stale is recomputed each redirect from the current inflight.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32 bits) and perf_redirects (32 bits).
  - perf_fetched increments per decode handshake.
  - perf_redirects increments per redirect_F cycle.
  - Both wrap, and reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, DEPTH=4, memory always ready, 1-cycle response, decode always ready -> requests at 0x0, 0x4, 0x8, …; instr_valid_D first high 2 cycles after the first accept, then one instruction per cycle, with pc_D matching.
- Decode held not-ready -> exactly 4 requests accepted, then imem_req_valid=0; on decode ready, 4 in-order pops with PCs 0x0–0xC, then fetch resumes at 0x10.
- Memory response delay 3 cycles, 2 requests in flight, redirect_F=1 with PCBranch_F=0x100 -> both old responses discarded, queue empty, next request addr 0x100, and the first delivered pc_D is 0x100.
- Redirect in the same cycle as a response and a decode-ready -> no pop occurs; stale = inflight-1; the subsequent target instructions are delivered correctly.
- reset=0 asserted while the queue is full with requests in flight (memory then quiesced) -> next cycle outputs at reset values; fetch restarts at RESET_PC=0x400 (bench parameter).
- FETCH_PERF_CNT_EN defined, 10 pops and 2 redirects -> perf_fetched=10, perf_redirects=2; after reset both read 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generator, imem request/response handshake and a
// DEPTH-entry in-order instruction queue with redirect flush. FETCH_PERF_CNT_EN adds perf counters.
module fetch_queue #(
   parameter int             N        = 64,
   parameter int             INSN_W   = 32,
   parameter int             DEPTH    = 4,
   parameter logic [N-1:0]   RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect_F,
   input  logic [N-1:0]      PCBranch_F,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [N-1:0]      imem_addr_F,
   input  logic              imem_rsp_valid,
   input  logic [INSN_W-1:0] imem_rsp_data,
   output logic              instr_valid_D,
   input  logic              instr_ready_D,
   output logic [INSN_W-1:0] instr_D,
   output logic [N-1:0]      pc_D
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_redirects
`endif
);

   localparam int            PW      = $clog2(DEPTH);
   localparam int            CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [N-1:0]  STEP    = N'(INSN_W / 8);

   logic [N-1:0]      pc_reg;
   logic [PW-1:0]     alloc_ptr_reg;
   logic [PW-1:0]     fill_ptr_reg;
   logic [PW-1:0]     head_ptr_reg;
   logic [CW-1:0]     count_reg;
   logic [CW-1:0]     inflight_reg;
   logic [CW-1:0]     stale_reg;
   logic [DEPTH-1:0]  filled_reg;
   logic [N-1:0]      entry_pc_reg   [DEPTH];
   logic [INSN_W-1:0] entry_insn_reg [DEPTH];

   logic              req_fire;
   logic              pop_fire;
   logic              fill_en;
   logic [CW-1:0]     count_next;
   logic [CW-1:0]     inflight_next;

   assign imem_req_valid = reset && !redirect_F && (count_reg < DEPTH_C) && (inflight_reg < DEPTH_C);
   assign imem_addr_F    = pc_reg;
   assign instr_valid_D  = !redirect_F && (count_reg != '0) && filled_reg[head_ptr_reg];
   assign instr_D        = (count_reg != '0) ? entry_insn_reg[head_ptr_reg] : '0;
   assign pc_D           = (count_reg != '0) ? entry_pc_reg[head_ptr_reg] : '0;

   // Both handshakes are already masked by redirect_F, so inflight_next is also the stale load value.
   always_comb begin
      req_fire      = imem_req_valid && imem_req_ready;
      pop_fire      = instr_valid_D && instr_ready_D;
      fill_en       = imem_rsp_valid && (stale_reg == '0);
      count_next    = count_reg + CW'(req_fire) - CW'(pop_fire);
      inflight_next = inflight_reg + CW'(req_fire) - CW'(imem_rsp_valid);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg        <= RESET_PC;
         alloc_ptr_reg <= '0;
         fill_ptr_reg  <= '0;
         head_ptr_reg  <= '0;
         count_reg     <= '0;
         inflight_reg  <= '0;
         stale_reg     <= '0;
         filled_reg    <= '0;
      end else begin
         inflight_reg <= inflight_next;
         if (redirect_F) begin
            pc_reg        <= PCBranch_F;
            alloc_ptr_reg <= '0;
            fill_ptr_reg  <= '0;
            head_ptr_reg  <= '0;
            count_reg     <= '0;
            filled_reg    <= '0;
            stale_reg     <= inflight_next;
         end else begin
            count_reg <= count_next;
            if (req_fire) begin
               pc_reg                    <= pc_reg + STEP;
               alloc_ptr_reg             <= alloc_ptr_reg + PW'(1);
               filled_reg[alloc_ptr_reg] <= 1'b0;
            end
            if (imem_rsp_valid) begin
               if (stale_reg != '0) begin
                  stale_reg <= stale_reg - CW'(1);
               end else begin
                  filled_reg[fill_ptr_reg] <= 1'b1;
                  fill_ptr_reg             <= fill_ptr_reg + PW'(1);
               end
            end
            if (pop_fire) begin
               head_ptr_reg <= head_ptr_reg + PW'(1);
            end
         end
      end
   end

   // Payload storage needs no reset: the head is only exposed while count is non-zero.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         entry_pc_reg[alloc_ptr_reg] <= pc_reg;
      end
      if (fill_en) begin
         entry_insn_reg[fill_ptr_reg] <= imem_rsp_data;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_redirects_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         perf_fetched_reg   <= '0;
         perf_redirects_reg <= '0;
      end else begin
         if (pop_fire) begin
            perf_fetched_reg <= perf_fetched_reg + 32'd1;
         end
         if (redirect_F) begin
            perf_redirects_reg <= perf_redirects_reg + 32'd1;
         end
      end
   end

   assign perf_fetched   = perf_fetched_reg;
   assign perf_redirects = perf_redirects_reg;
`endif

endmodule
